// File: rtl/gerador_pkg.sv
// Shared types and defaults for the period generator and its time base.
package gerador_pkg;

  typedef enum logic [1:0] {
    ESTACIONADO = 2'd0,
    ALTO        = 2'd1,
    BAIXO       = 2'd2,
    FEITO       = 2'd3
  } estado_t;

  localparam int unsigned PERIODO_MIN_MS_PADRAO = 2;

  // Upper half of a period, ceil(p/2), written without p+1 so 32'hFFFFFFFF cannot overflow.
  function automatic logic [31:0] meio_superior(input logic [31:0] p);
    return p - (p >> 1);
  endfunction

endpackage

// File: rtl/base_de_tempo_ms.sv
// Millisecond time base: one-cycle tick_ms every CICLOS_POR_MS cycles, phase-aligned to clear.
// Latency: first tick in the CICLOS_POR_MS-th cycle after clear drops; no backpressure.
module base_de_tempo_ms #(
  parameter int unsigned CICLOS_POR_MS = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick_ms
);

  localparam int unsigned W = (CICLOS_POR_MS > 1) ? $clog2(CICLOS_POR_MS) : 1;
  localparam logic [W-1:0] ULTIMO = W'(CICLOS_POR_MS - 1);

  logic [W-1:0] cnt_ciclos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ciclos <= '0;
    end else if (clear || cnt_ciclos == ULTIMO) begin
      cnt_ciclos <= '0;
    end else begin
      cnt_ciclos <= cnt_ciclos + 1'b1;
    end
  end

  assign tick_ms = !clear && (cnt_ciclos == ULTIMO);

endmodule

// File: rtl/gerador_de_periodos.sv
// Square-wave generator: n_periodos periods of periodo_ms ms, high half first; 1-cycle start latency.
// start is only honoured while ready; GERADOR_CONTINUO_EN makes n_periodos=0 run until stop.
module gerador_de_periodos
  import gerador_pkg::*;
#(
  parameter int unsigned CICLOS_POR_MS  = 1000,
  parameter int unsigned PERIODO_MIN_MS = PERIODO_MIN_MS_PADRAO
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] periodo_ms,
  input  logic [15:0] n_periodos,
  input  logic        stop,
  output logic        sinal_out,
  output logic        ready,
  output logic        done,
  output logic        erro,
  output logic [15:0] periodos_gerados
);

  estado_t     estado, estado_prox;
  logic [31:0] periodo_lat;
  logic [15:0] n_lat;
  logic [31:0] ms_cnt;
  logic [15:0] contagem, contagem_prox;
  logic [31:0] meio_alto, meio_baixo;
  logic        tick_ms;
  logic        params_ok, aceita, rejeita;
  logic        fim_alto, fim_baixo, pula_baixo, fim_fase, fim_periodo;
  logic        ultimo_periodo, em_execucao;
  logic        erro_q;

  assign meio_alto  = meio_superior(periodo_lat);
  assign meio_baixo = periodo_lat >> 1;
  assign pula_baixo = (meio_baixo == '0);

`ifdef GERADOR_CONTINUO_EN
  assign params_ok = (periodo_ms >= 32'(PERIODO_MIN_MS));
`else
  assign params_ok = (periodo_ms >= 32'(PERIODO_MIN_MS)) && (n_periodos != '0);
`endif

  assign aceita  = (estado == ESTACIONADO) && start && params_ok;
  assign rejeita = (estado == ESTACIONADO) && start && !params_ok;

  base_de_tempo_ms #(
    .CICLOS_POR_MS(CICLOS_POR_MS)
  ) u_base_de_tempo_ms (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (estado == ESTACIONADO),
    .tick_ms(tick_ms)
  );

  // Phases are whole milliseconds, so the free-running cycle counter stays aligned across phases.
  assign fim_alto    = tick_ms && (ms_cnt == meio_alto - 32'd1);
  assign fim_baixo   = tick_ms && (ms_cnt == meio_baixo - 32'd1);
  assign em_execucao = (estado == ALTO) || (estado == BAIXO);
  assign fim_fase    = ((estado == ALTO) && fim_alto) || ((estado == BAIXO) && fim_baixo);
  assign fim_periodo = ((estado == BAIXO) && fim_baixo) ||
                       ((estado == ALTO) && fim_alto && pula_baixo);

  // Saturating count; n_lat=0 (continuous) never matches, so the run only ends on stop.
  assign contagem_prox  = (contagem == 16'hFFFF) ? contagem : contagem + 16'd1;
  assign ultimo_periodo = (n_lat != '0) && (contagem_prox == n_lat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= ESTACIONADO;
    end else begin
      estado <= estado_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    sinal_out   = 1'b0;
    ready       = 1'b0;
    done        = 1'b0;
    case (estado)
      ESTACIONADO: begin
        ready = 1'b1;
        if (aceita) begin
          estado_prox = ALTO;
        end
      end
      ALTO: begin
        sinal_out = 1'b1;
        if (stop) begin
          estado_prox = FEITO;
        end else if (fim_alto) begin
          if (!pula_baixo) begin
            estado_prox = BAIXO;
          end else begin
            estado_prox = ultimo_periodo ? FEITO : ALTO;
          end
        end
      end
      BAIXO: begin
        if (stop) begin
          estado_prox = FEITO;
        end else if (fim_baixo) begin
          estado_prox = ultimo_periodo ? FEITO : ALTO;
        end
      end
      FEITO: begin
        done        = 1'b1;
        estado_prox = ESTACIONADO;
      end
      default: begin
        estado_prox = ESTACIONADO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      periodo_lat <= '0;
      n_lat       <= '0;
      ms_cnt      <= '0;
      contagem    <= '0;
      erro_q      <= 1'b0;
    end else begin
      erro_q <= rejeita;
      if (aceita) begin
        periodo_lat <= periodo_ms;
        n_lat       <= n_periodos;
        ms_cnt      <= '0;
        contagem    <= '0;
      end else if (em_execucao && !stop) begin
        // stop wins over a coinciding phase end: the count stays frozen.
        if (fim_periodo) begin
          contagem <= contagem_prox;
        end
        if (fim_fase) begin
          ms_cnt <= '0;
        end else if (tick_ms) begin
          ms_cnt <= ms_cnt + 32'd1;
        end
      end
    end
  end

  assign erro             = erro_q;
  assign periodos_gerados = contagem;

endmodule

// File: tb/tb_gerador_de_periodos.sv
// Bench for gerador_de_periodos at CICLOS_POR_MS=4: per-cycle arithmetic model plus literal checkpoints.
module tb_gerador_de_periodos;

  localparam int C = 4;
  localparam int PMIN = 2;
`ifdef GERADOR_CONTINUO_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] periodo_ms = '0;
  logic [15:0] n_periodos = '0;
  logic        stop = 1'b0;
  logic        sinal_out, ready, done, erro;
  logic [15:0] periodos_gerados;

  int n_asserts = 0;
  int n_fail = 0;

  gerador_de_periodos #(
    .CICLOS_POR_MS(C)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .periodo_ms      (periodo_ms),
    .n_periodos      (n_periodos),
    .stop            (stop),
    .sinal_out       (sinal_out),
    .ready           (ready),
    .done            (done),
    .erro            (erro),
    .periodos_gerados(periodos_gerados)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nome, input int atual, input int esperado);
    n_asserts++;
    if (atual != esperado) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  // Model: run position m_k (1 = first cycle after acceptance) and the cycle done is due.
  bit m_run = 1'b0;
  bit m_erro = 1'b0;
  int m_k = 0, m_done_k = 0, m_P = 0, m_N = 0, m_fin = 0, m_last = 0;

  function automatic int periodos_em(input int k, input int p);
    int v;
    v = (k - 1) / (p * C);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Inputs change just after posedge, so at negedge they equal what the next edge samples.
  initial begin
    int e_s, e_r, e_d, e_p;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_run = 1'b0; m_erro = 1'b0; m_last = 0;
      end
      if (!m_run) begin
        e_s = 0; e_r = 1; e_d = 0; e_p = m_last;
      end else if (m_k == m_done_k) begin
        e_s = 0; e_r = 0; e_d = 1; e_p = m_fin;
      end else begin
        e_s = (((m_k - 1) % (m_P * C)) < (m_P - m_P / 2) * C) ? 1 : 0;
        e_r = 0; e_d = 0; e_p = periodos_em(m_k, m_P);
      end
      chk("sinal_out", int'(sinal_out), e_s);
      chk("ready", int'(ready), e_r);
      chk("done", int'(done), e_d);
      chk("erro", int'(erro), int'(m_erro));
      chk("periodos_gerados", int'(periodos_gerados), e_p);
      if (rst_n) begin
        m_erro = 1'b0;
        if (!m_run) begin
          if (start) begin
            if (periodo_ms >= PMIN && (n_periodos != 0 || CONT)) begin
              m_run = 1'b1; m_k = 1;
              m_P = int'(periodo_ms); m_N = int'(n_periodos);
              m_done_k = (m_N == 0) ? 32'h7FFFFFFF : m_N * m_P * C + 1;
              m_fin = m_N;
            end else begin
              m_erro = 1'b1;
            end
          end
        end else if (m_k == m_done_k) begin
          m_run = 1'b0; m_last = m_fin;
        end else begin
          if (stop) begin
            m_done_k = m_k + 1;
            m_fin = periodos_em(m_k, m_P);
          end
          m_k++;
        end
      end
    end
  end

  task automatic ciclo(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic dispara(input int p, input int n);
    periodo_ms = 32'(p);
    n_periodos = 16'(n);
    start = 1'b1;
    ciclo(1);
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst ready", int'(ready), 1);
    chk("rst sinal_out", int'(sinal_out), 0);
    chk("rst done", int'(done), 0);
    chk("rst erro", int'(erro), 0);
    chk("rst periodos", int'(periodos_gerados), 0);
    ciclo(2);
    rst_n = 1'b1;

    // P=4, N=2, started on the first edge after reset release; mid-run start ignored
    dispara(4, 2);
    chk("A c1 sinal", int'(sinal_out), 1);
    ciclo(7);
    chk("A c8 sinal", int'(sinal_out), 1);
    ciclo(1);
    chk("A c9 sinal", int'(sinal_out), 0);
    ciclo(8);
    chk("A c17 sinal", int'(sinal_out), 1);
    chk("A c17 periodos", int'(periodos_gerados), 1);
    start = 1'b1; periodo_ms = 32'd2;
    ciclo(1);
    start = 1'b0;
    chk("A start ignored erro", int'(erro), 0);
    ciclo(15);
    chk("A c33 done", int'(done), 1);
    chk("A c33 periodos", int'(periodos_gerados), 2);
    ciclo(1);
    chk("A c34 ready", int'(ready), 1);
    chk("A c34 done", int'(done), 0);

    // Stop while idle is ignored
    stop = 1'b1;
    ciclo(2);
    stop = 1'b0;
    chk("idle stop ready", int'(ready), 1);

    // P=3, N=1: 8 high, 4 low
    dispara(3, 1);
    ciclo(7);
    chk("B c8 sinal", int'(sinal_out), 1);
    ciclo(1);
    chk("B c9 sinal", int'(sinal_out), 0);
    ciclo(3);
    chk("B c12 done", int'(done), 0);
    ciclo(1);
    chk("B c13 done", int'(done), 1);
    chk("B c13 periodos", int'(periodos_gerados), 1);
    ciclo(2);

    // P=1 rejected
    dispara(1, 1);
    chk("C erro", int'(erro), 1);
    chk("C ready", int'(ready), 1);
    chk("C sinal", int'(sinal_out), 0);
    ciclo(1);
    chk("C erro single", int'(erro), 0);

    // P=4, N=3, stop in cycle 5 of the first BAIXO (cycle 13)
    dispara(4, 3);
    ciclo(12);
    chk("D c13 sinal", int'(sinal_out), 0);
    stop = 1'b1;
    ciclo(1);
    stop = 1'b0;
    chk("D done", int'(done), 1);
    chk("D sinal", int'(sinal_out), 0);
    chk("D periodos", int'(periodos_gerados), 0);
    ciclo(2);

    // Reset pulse mid-ALTO, then a fresh run
    dispara(4, 2);
    ciclo(2);
    rst_n = 1'b0;
    #1;
    chk("E rst sinal", int'(sinal_out), 0);
    chk("E rst ready", int'(ready), 1);
    chk("E rst done", int'(done), 0);
    ciclo(1);
    rst_n = 1'b1;
    dispara(4, 2);
    chk("E c1 sinal", int'(sinal_out), 1);
    ciclo(32);
    chk("E c33 done", int'(done), 1);
    chk("E c33 periodos", int'(periodos_gerados), 2);
    ciclo(2);

    // n_periodos=0: continuous with the macro, rejected without
`ifdef GERADOR_CONTINUO_EN
    dispara(2, 0);
    chk("F c1 sinal", int'(sinal_out), 1);
    ciclo(4);
    chk("F c5 sinal", int'(sinal_out), 0);
    ciclo(4);
    chk("F c9 sinal", int'(sinal_out), 1);
    ciclo(8);
    chk("F c17 sinal", int'(sinal_out), 1);
    ciclo(3);
    stop = 1'b1;
    ciclo(1);
    stop = 1'b0;
    chk("F done", int'(done), 1);
    chk("F periodos", int'(periodos_gerados), 2);
`else
    dispara(2, 0);
    chk("F erro", int'(erro), 1);
    chk("F sinal", int'(sinal_out), 0);
`endif
    ciclo(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
